dm_cache_ctrl: RTL and testbench
================================

# dm_cache_ctrl

Sequencing controller for the 6-bit-address, 32-bit-data direct-mapped cache: owns tag/valid/data arrays (4 lines × 4 words), accepts one CPU request at a time, serves hits locally, and runs a 4-word burst refill from main memory on read misses. Writes are write-through, no-write-allocate. Sits between the CPU load/store port and the main-memory port.

## Interface
- DATA_W, 32, data word width (address split is fixed: tag [5:4], index [3:2], offset [1:0], word-addressed)
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- cpu_req  input  1  request valid; held with cpu_we/addr/wdata stable until cpu_ready
- cpu_we  input  1  1 = write, 0 = read
- cpu_addr  input  6  word address
- cpu_wdata  input  DATA_W  write data
- cpu_ready  output  1  one-cycle completion pulse
- cpu_hit  output  1  valid with cpu_ready: 1 = request hit in cache
- cpu_rdata  output  DATA_W  read data, valid with cpu_ready on reads
- mem_req  output  1  memory request, held until mem_ack for every beat
- mem_we  output  1  1 = memory write
- mem_addr  output  6  memory word address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data, valid when mem_ack=1
- mem_ack  input  1  beat complete; transfer occurs on edge with mem_req && mem_ack

## Operation
- States: IDLE, LOOKUP, REFILL, WRITE, RESP.
- IDLE: cpu_req=1 at edge -> latch we/addr/wdata, go LOOKUP. cpu_req ignored in any other state.
- LOOKUP: hit = valid[index] && tag[index]==addr[5:4].
  - Read hit -> register cpu_rdata=data[index][offset], cpu_ready=1, cpu_hit=1; go IDLE.
  - Read miss -> clear valid[index], cnt=0, go REFILL.
  - Write (hit or miss) -> on hit write data[index][offset]=wdata; record hit; drive mem_req=1, mem_we=1, mem_addr=addr, mem_wdata=wdata; go WRITE.
- REFILL: mem_req=1, mem_we=0, mem_addr={tag,index,cnt}. Each acked beat writes mem_rdata to data[index][cnt], cnt++. On 4th ack (cnt 3 -> wraps 0): set tag[index], valid[index]=1, deassert mem_req, go RESP.
- RESP: cpu_rdata=data[index][offset], cpu_ready=1, cpu_hit=0; go IDLE.
- WRITE: hold mem_* until mem_ack; then mem_req=0, cpu_ready=1, cpu_hit=recorded hit, cpu_rdata unchanged; go IDLE. Write miss never allocates or alters any line.
- Conflict: refill to a valid line with different tag overwrites it (no write-back needed, write-through).

## Timing
- All outputs registered. Reset values: cpu_ready 0, cpu_hit 0, cpu_rdata 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0; state IDLE; all valid bits 0, cnt 0. Data/tag arrays not reset.
- Read hit: request edge E0, cpu_ready high in cycle after E1 (2-edge latency).
- Read miss with mem_ack tied 1: 4 beat edges after LOOKUP, cpu_ready one cycle after RESP entry; total 7 edges from E0.
- Write with mem_ack tied 1: cpu_ready high after E2+1, i.e. 3-edge latency.
- cpu_ready is exactly one cycle; requester may present next request during that cycle, accepted at the following edge (back-to-back, no bubble beyond IDLE).
- mem_ack low stalls indefinitely; mem_req and mem_addr stay constant while stalled.
- Reset asserted mid-REFILL/WRITE: immediate return to IDLE, mem_req 0, line being refilled stays invalid; no cpu_ready issued.

## Test plan
- Memory model word(a)=32'hA000_0000|a, mem_ack=1. Cold read 6'b100111 -> mem_addr 0x24,0x25,0x26,0x27; cpu_ready with cpu_hit=0, cpu_rdata=32'hA000_0027.
- Then read 6'b100100 -> cpu_hit=1, cpu_rdata=32'hA000_0024, 2-edge latency, no mem_req.
- Write 6'b100101 data 32'h9876_432C -> mem write at 0x25, cpu_hit=1; read 0x25 -> hit, 32'h9876_432C.
- Write miss 6'b001110 data 32'hABCD_1234 -> mem write, cpu_hit=0; read 0x0E -> miss/refill, returns memory value (no allocate on write).
- Conflict: after line 1 holds tag 2, read 6'b110111 -> refill 0x34–0x37, returns 32'hA000_0037; re-read 0x27 -> miss again.
- mem_ack pulsed every 3rd cycle during refill -> mem_addr stable while stalled, correct data; assert rst after 2nd beat -> IDLE, mem_req 0, subsequent read of that line misses.

Source files
------------

// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: sequencing controller for a 4-line x 4-word direct-mapped
// cache. Address split is tag[5:4] / index[3:2] / offset[1:0] (word address).
// Read misses run a 4-beat refill; writes are write-through, no-write-allocate.
module dm_cache_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [5:0]        cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_hit,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [5:0]        mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_REFILL, S_WRITE, S_RESP} state_t;

  state_t state, state_nxt;

  // Latched request; only sampled in IDLE so the CPU side is free afterwards.
  logic              req_we;
  logic [5:0]        req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              hit_q;
  logic [1:0]        cnt;
  logic [3:0]        valid;

  logic [1:0]        tag_arr  [4];
  logic [DATA_W-1:0] data_arr [4][4];

  logic [1:0] req_tag, req_idx, req_off;
  logic       lookup_hit, beat, last_beat;

  assign req_tag    = req_addr[5:4];
  assign req_idx    = req_addr[3:2];
  assign req_off    = req_addr[1:0];
  assign lookup_hit = valid[req_idx] && (tag_arr[req_idx] == req_tag);
  assign beat       = mem_req && mem_ack;
  assign last_beat  = beat && (cnt == 2'd3);

  // Next-value signals for the registered outputs.
  logic              ready_d, hit_d, mreq_d, mwe_d;
  logic [DATA_W-1:0] rdata_d, mwdata_d;
  logic [5:0]        maddr_d;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (cpu_req) state_nxt = S_LOOKUP;
      S_LOOKUP: begin
        if (req_we)          state_nxt = S_WRITE;
        else if (lookup_hit) state_nxt = S_IDLE;
        else                 state_nxt = S_REFILL;
      end
      S_REFILL: if (last_beat) state_nxt = S_RESP;
      S_WRITE:  if (beat) state_nxt = S_IDLE;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered CPU/memory-side outputs.
  // Unless a state says otherwise, outputs hold (cpu_ready always drops).
  always_comb begin
    ready_d  = 1'b0;
    hit_d    = cpu_hit;
    rdata_d  = cpu_rdata;
    mreq_d   = mem_req;
    mwe_d    = mem_we;
    maddr_d  = mem_addr;
    mwdata_d = mem_wdata;
    case (state)
      S_LOOKUP: begin
        if (req_we) begin
          mreq_d   = 1'b1;
          mwe_d    = 1'b1;
          maddr_d  = req_addr;
          mwdata_d = req_wdata;
        end else if (lookup_hit) begin
          ready_d = 1'b1;
          hit_d   = 1'b1;
          rdata_d = data_arr[req_idx][req_off];
        end else begin
          mreq_d  = 1'b1;
          mwe_d   = 1'b0;
          maddr_d = {req_tag, req_idx, 2'b00};
        end
      end
      S_REFILL: begin
        if (beat) begin
          maddr_d = {req_tag, req_idx, cnt + 2'd1};
          if (cnt == 2'd3) mreq_d = 1'b0;
        end
      end
      S_WRITE: begin
        if (beat) begin
          mreq_d  = 1'b0;
          ready_d = 1'b1;
          hit_d   = hit_q;
        end
      end
      S_RESP: begin
        ready_d = 1'b1;
        hit_d   = 1'b0;
        rdata_d = data_arr[req_idx][req_off];
      end
      default: ;
    endcase
  end

  // Registered outputs and control state (valid bits, beat counter, request latch).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_ready <= 1'b0;
      cpu_hit   <= 1'b0;
      cpu_rdata <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      hit_q     <= 1'b0;
      cnt       <= 2'd0;
      valid     <= 4'b0;
    end else begin
      cpu_ready <= ready_d;
      cpu_hit   <= hit_d;
      cpu_rdata <= rdata_d;
      mem_req   <= mreq_d;
      mem_we    <= mwe_d;
      mem_addr  <= maddr_d;
      mem_wdata <= mwdata_d;
      if (state == S_IDLE && cpu_req) begin
        req_we    <= cpu_we;
        req_addr  <= cpu_addr;
        req_wdata <= cpu_wdata;
      end
      if (state == S_LOOKUP) begin
        hit_q <= lookup_hit;
        cnt   <= 2'd0;
        // A read miss invalidates the line up front so an aborted refill
        // can never leave a half-filled line marked valid.
        if (!req_we && !lookup_hit) valid[req_idx] <= 1'b0;
      end
      if (state == S_REFILL && beat) begin
        cnt <= cnt + 2'd1;
        if (cnt == 2'd3) valid[req_idx] <= 1'b1;
      end
    end
  end

  // Tag/data arrays: no reset, contents are qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (state == S_LOOKUP && req_we && lookup_hit)
      data_arr[req_idx][req_off] <= req_wdata;
    if (state == S_REFILL && beat) begin
      data_arr[req_idx][cnt] <= mem_rdata;
      if (cnt == 2'd3) tag_arr[req_idx] <= req_tag;
    end
  end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Bench for dm_cache_ctrl: directed scenarios then random traffic, checked
// against a line-level cache model (valid/tag per line) and a reference memory.
module tb_dm_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [5:0]  cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_ready, cpu_hit;
  logic [31:0] cpu_rdata;
  logic        mem_req, mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack = 1'b1;

  dm_cache_ctrl #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_hit(cpu_hit), .cpu_rdata(cpu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // External memory seen by the DUT, and the reference copy the model keeps.
  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];
  assign mem_rdata = mem[mem_addr];

  // Cache model: which tag each line holds, if any.
  bit       mvalid [4];
  bit [1:0] mtag   [4];

  // ack_mode 0: tied high, 1: every 3rd cycle, 2: random.
  int ack_mode = 0;
  int cyc = 0;
  always @(negedge clk) begin
    cyc++;
    case (ack_mode)
      0:       mem_ack = 1'b1;
      1:       mem_ack = (cyc % 3 == 0);
      default: mem_ack = 1'($urandom_range(0, 1));
    endcase
  end

  // Memory side: log every completed beat, apply writes, and watch that a
  // stalled request keeps its address.
  logic [38:0] xfer_q[$];
  bit          stall_prev = 0;
  logic [5:0]  last_addr = '0;
  always @(posedge clk) begin
    if (rst && stall_prev) begin
      chk("req_held", mem_req, 1);
      chk("addr_stable", mem_addr, last_addr);
    end
    if (mem_req && mem_ack) begin
      xfer_q.push_back({mem_we, mem_addr, mem_we ? mem_wdata : mem_rdata});
      if (mem_we) mem[mem_addr] = mem_wdata;
    end
    stall_prev = mem_req && !mem_ack;
    last_addr  = mem_addr;
  end

  // One CPU request; returns once cpu_ready has been seen (at edge+1), so
  // consecutive calls present back-to-back requests.
  task automatic do_req(input bit we, input logic [5:0] a, input logic [31:0] d);
    bit          exp_hit, got;
    int          edges;
    logic [1:0]  idx;
    logic [38:0] exp_x [$];
    idx     = a[3:2];
    exp_hit = mvalid[idx] && (mtag[idx] == a[5:4]);
    xfer_q.delete();
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    edges = 0; got = 0;
    while (!got && edges < 400) begin
      @(posedge clk); #1;
      edges++;
      if (cpu_ready) got = 1;
    end
    cpu_req = 1'b0;
    chk("ready_seen", got, 1);
    if (!got) return;
    chk("hit", cpu_hit, exp_hit);
    if (!we) chk("rdata", cpu_rdata, ref_mem[a]);
    if (ack_mode == 0) chk("latency", edges, we ? 3 : (exp_hit ? 2 : 7));
    if (we) begin
      exp_x.push_back({1'b1, a, d});
      ref_mem[a] = d;
    end else if (!exp_hit) begin
      for (int k = 0; k < 4; k++)
        exp_x.push_back({1'b0, a[5:2], 2'(k), ref_mem[{a[5:2], 2'(k)}]});
      mvalid[idx] = 1;
      mtag[idx]   = a[5:4];
    end
    chk("xfer_n", xfer_q.size(), exp_x.size());
    if (xfer_q.size() == exp_x.size())
      foreach (exp_x[k]) chk("xfer", xfer_q[k], exp_x[k]);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 32'hA000_0000 | i;
      ref_mem[i] = 32'hA000_0000 | i;
    end
    for (int i = 0; i < 4; i++) begin mvalid[i] = 0; mtag[i] = 0; end

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_ready", cpu_ready, 0);
    chk("rst_hit", cpu_hit, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_mreq", mem_req, 0);
    chk("rst_mwe", mem_we, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_mwdata", mem_wdata, 0);
    rst = 1'b1;
    @(negedge clk);

    // Directed sequence with mem_ack tied high.
    do_req(0, 6'b100111, 0);
    chk("cold_rdata", cpu_rdata, 32'hA000_0027);
    do_req(0, 6'b100100, 0);
    chk("hit_rdata", cpu_rdata, 32'hA000_0024);
    do_req(1, 6'b100101, 32'h9876_432C);
    do_req(0, 6'b100101, 0);
    chk("wr_hit_rdata", cpu_rdata, 32'h9876_432C);
    do_req(1, 6'b001110, 32'hABCD_1234);
    do_req(0, 6'b001110, 0);
    chk("wr_miss_rdata", cpu_rdata, 32'hABCD_1234);
    do_req(0, 6'b110111, 0);
    chk("conflict_rdata", cpu_rdata, 32'hA000_0037);
    do_req(0, 6'b100111, 0);
    @(posedge clk); #1;
    chk("ready_one_cycle", cpu_ready, 0);

    // Stalled refill, then reset in the middle of a second refill.
    ack_mode = 1;
    do_req(0, 6'b000101, 0);
    xfer_q.delete();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'b010010;
    for (int e = 0; e < 100 && xfer_q.size() < 2; e++) begin
      @(posedge clk); #1;
    end
    cpu_req = 1'b0;
    chk("abort_beats", xfer_q.size(), 2);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_mreq", mem_req, 0);
    chk("abort_ready", cpu_ready, 0);
    for (int i = 0; i < 4; i++) mvalid[i] = 0;
    @(negedge clk);
    rst = 1'b1;
    ack_mode = 0;
    @(negedge clk);
    do_req(0, 6'b010010, 0);
    chk("after_abort_miss", cpu_hit, 0);

    // Random traffic, ack tied or random.
    for (int n = 0; n < 200; n++) begin
      ack_mode = ($urandom_range(0, 2) == 0) ? 2 : 0;
      do_req(1'($urandom_range(0, 3) == 0), 6'($urandom_range(0, 63)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
